// File: rtl/ysyx_24070014_lsu_pkg.sv
// Shared definitions for the load/store unit: access sizes, FSM states,
// byte-strobe masks and the alignment helper.
package ysyx_24070014_lsu_pkg;

  localparam logic [1:0] ysyx_24070014_SIZE_B = 2'b00;
  localparam logic [1:0] ysyx_24070014_SIZE_H = 2'b01;
  localparam logic [1:0] ysyx_24070014_SIZE_W = 2'b10;
  localparam logic [1:0] ysyx_24070014_SIZE_D = 2'b11;

  localparam logic [7:0] ysyx_24070014_STRB_B = 8'h01;
  localparam logic [7:0] ysyx_24070014_STRB_H = 8'h03;
  localparam logic [7:0] ysyx_24070014_STRB_W = 8'h0F;
  localparam logic [7:0] ysyx_24070014_STRB_D = 8'hFF;

  typedef enum logic [1:0] {
    ysyx_24070014_IDLE = 2'd0,
    ysyx_24070014_REQ  = 2'd1,
    ysyx_24070014_WAIT = 2'd2,
    ysyx_24070014_RESP = 2'd3
  } ysyx_24070014_state_e;

  // Control fields captured when a request is accepted.
  typedef struct packed {
    logic       write;
    logic [1:0] size;
    logic       is_unsigned;
  } ysyx_24070014_ctrl_t;

  function automatic logic [7:0] ysyx_24070014_strb_mask(input logic [1:0] size);
    case (size)
      ysyx_24070014_SIZE_B: return ysyx_24070014_STRB_B;
      ysyx_24070014_SIZE_H: return ysyx_24070014_STRB_H;
      ysyx_24070014_SIZE_W: return ysyx_24070014_STRB_W;
      default:              return ysyx_24070014_STRB_D;
    endcase
  endfunction

  function automatic logic ysyx_24070014_aligned(input logic [1:0] size,
                                                 input logic [2:0] addr_lo);
    case (size)
      ysyx_24070014_SIZE_B: return 1'b1;
      ysyx_24070014_SIZE_H: return addr_lo[0] == 1'b0;
      ysyx_24070014_SIZE_W: return addr_lo[1:0] == 2'b00;
      default:              return addr_lo == 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_24070014_LaneAlign.sv
// Byte-lane placement for stores and lane extraction plus sign/zero
// extension for loads. Purely combinational.
module ysyx_24070014_LaneAlign
  import ysyx_24070014_lsu_pkg::*;
#(
  parameter int unsigned DATA_LEN = 32
) (
  input  logic [1:0]                       i_size,
  input  logic                             i_unsigned,
  input  logic [$clog2(DATA_LEN/8)-1:0]    i_offset,
  input  logic [DATA_LEN-1:0]              i_wdata,
  input  logic [DATA_LEN-1:0]              i_rdata,
  output logic [DATA_LEN-1:0]              o_lane_wdata,
  output logic [DATA_LEN/8-1:0]            o_lane_wstrb,
  output logic [DATA_LEN-1:0]              o_ext_rdata
);

  localparam int unsigned NB = DATA_LEN / 8;
  localparam int unsigned IW = $clog2(DATA_LEN);

  logic [DATA_LEN-1:0] w_rshift;
  logic [IW-1:0]       w_top;
  logic                w_fill;

  assign o_lane_wdata = i_wdata << {i_offset, 3'b000};
  assign o_lane_wstrb = NB'(ysyx_24070014_strb_mask(i_size)) << i_offset;
  assign w_rshift     = i_rdata >> {i_offset, 3'b000};

  // Bits above the access width are filled with the sign bit or zero.
  always_comb begin
    w_top       = IW'(DATA_LEN - 1);
    o_ext_rdata = '0;
    case (i_size)
      ysyx_24070014_SIZE_B: w_top = IW'(7);
      ysyx_24070014_SIZE_H: w_top = IW'(15);
      ysyx_24070014_SIZE_W: w_top = IW'(31);
      default:              w_top = IW'(DATA_LEN - 1);
    endcase
    w_fill = ~i_unsigned & w_rshift[w_top];
    for (int i = 0; i < int'(DATA_LEN); i++) begin
      o_ext_rdata[i] = (IW'(i) <= w_top) ? w_rshift[i] : w_fill;
    end
  end

endmodule

// File: rtl/ysyx_24070014_lsu.sv
// Load/store unit: accepts one core request at a time, issues a single
// memory transaction and returns one response pulse (with timeout).
module ysyx_24070014_lsu
  import ysyx_24070014_lsu_pkg::*;
#(
  parameter int unsigned DATA_LEN = 32,
  parameter int unsigned ADDR_LEN = 32,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_LEN-1:0]   req_addr,
  input  logic [DATA_LEN-1:0]   req_wdata,
  output logic                  resp_valid,
  output logic [DATA_LEN-1:0]   resp_rdata,
  output logic                  resp_err,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_LEN-1:0]   mem_addr,
  output logic                  mem_wen,
  output logic [DATA_LEN-1:0]   mem_wdata,
  output logic [DATA_LEN/8-1:0] mem_wstrb,
  input  logic                  mem_resp_valid,
  input  logic [DATA_LEN-1:0]   mem_rdata
);

  localparam int unsigned NB = DATA_LEN / 8;
  localparam int unsigned OW = $clog2(NB);
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  ysyx_24070014_state_e r_state, w_state_nxt;
  ysyx_24070014_ctrl_t  r_ctrl, w_ctrl_nxt;
  logic [OW-1:0]        r_off, w_off_nxt;
  logic [CW-1:0]        r_cnt, w_cnt_nxt, w_cnt_inc;

  logic                 r_req_ready, w_req_ready_nxt;
  logic                 r_resp_valid, w_resp_valid_nxt;
  logic                 r_resp_err, w_resp_err_nxt;
  logic [DATA_LEN-1:0]  r_resp_rdata, w_resp_rdata_nxt;
  logic                 r_mem_req_valid, w_mem_req_valid_nxt;
  logic [ADDR_LEN-1:0]  r_mem_addr, w_mem_addr_nxt;
  logic                 r_mem_wen, w_mem_wen_nxt;
  logic [DATA_LEN-1:0]  r_mem_wdata, w_mem_wdata_nxt;
  logic [NB-1:0]        r_mem_wstrb, w_mem_wstrb_nxt;

  logic                 w_req_ok;
  logic [1:0]           w_al_size;
  logic                 w_al_unsigned;
  logic [OW-1:0]        w_al_off;
  logic [DATA_LEN-1:0]  w_lane_wdata;
  logic [NB-1:0]        w_lane_wstrb;
  logic [DATA_LEN-1:0]  w_lane_rdata;

  assign w_req_ok = ((req_size != ysyx_24070014_SIZE_D) || (DATA_LEN == 64)) &&
                    ysyx_24070014_aligned(req_size, req_addr[2:0]);
  assign w_cnt_inc = r_cnt + CW'(1);

  // Lane unit sees the live request in IDLE (store placement) and the
  // captured fields afterwards (load extraction).
  assign w_al_size     = (r_state == ysyx_24070014_IDLE) ? req_size : r_ctrl.size;
  assign w_al_unsigned = (r_state == ysyx_24070014_IDLE) ? req_unsigned : r_ctrl.is_unsigned;
  assign w_al_off      = (r_state == ysyx_24070014_IDLE) ? req_addr[OW-1:0] : r_off;

  ysyx_24070014_LaneAlign #(
    .DATA_LEN (DATA_LEN)
  ) u_lane (
    .i_size       (w_al_size),
    .i_unsigned   (w_al_unsigned),
    .i_offset     (w_al_off),
    .i_wdata      (req_wdata),
    .i_rdata      (mem_rdata),
    .o_lane_wdata (w_lane_wdata),
    .o_lane_wstrb (w_lane_wstrb),
    .o_ext_rdata  (w_lane_rdata)
  );

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt         = r_state;
    w_ctrl_nxt          = r_ctrl;
    w_off_nxt           = r_off;
    w_cnt_nxt           = r_cnt;
    w_mem_addr_nxt      = r_mem_addr;
    w_mem_wen_nxt       = r_mem_wen;
    w_mem_wdata_nxt     = r_mem_wdata;
    w_mem_wstrb_nxt     = r_mem_wstrb;
    w_mem_req_valid_nxt = 1'b0;
    w_resp_valid_nxt    = 1'b0;
    w_resp_err_nxt      = 1'b0;
    w_resp_rdata_nxt    = '0;

    case (r_state)
      ysyx_24070014_IDLE: begin
        if (req_valid) begin
          w_ctrl_nxt.write       = req_write;
          w_ctrl_nxt.size        = req_size;
          w_ctrl_nxt.is_unsigned = req_unsigned;
          w_off_nxt              = req_addr[OW-1:0];
          w_mem_addr_nxt         = {req_addr[ADDR_LEN-1:OW], {OW{1'b0}}};
          if (w_req_ok) begin
            w_state_nxt         = ysyx_24070014_REQ;
            w_mem_req_valid_nxt = 1'b1;
            w_mem_wen_nxt       = req_write;
            w_mem_wdata_nxt     = req_write ? w_lane_wdata : '0;
            w_mem_wstrb_nxt     = req_write ? w_lane_wstrb : '0;
          end else begin
            w_state_nxt      = ysyx_24070014_RESP;
            w_resp_valid_nxt = 1'b1;
            w_resp_err_nxt   = 1'b1;
            w_mem_wen_nxt    = 1'b0;
            w_mem_wdata_nxt  = '0;
            w_mem_wstrb_nxt  = '0;
          end
        end
      end
      ysyx_24070014_REQ: begin
        w_mem_req_valid_nxt = 1'b1;
        if (mem_req_ready) begin
          w_state_nxt         = ysyx_24070014_WAIT;
          w_mem_req_valid_nxt = 1'b0;
          w_cnt_nxt           = '0;
        end
      end
      ysyx_24070014_WAIT: begin
        w_cnt_nxt = w_cnt_inc;
        // A response arriving on the timeout cycle still completes cleanly.
        if (mem_resp_valid) begin
          w_state_nxt      = ysyx_24070014_RESP;
          w_resp_valid_nxt = 1'b1;
          w_resp_rdata_nxt = r_ctrl.write ? '0 : w_lane_rdata;
        end else if (w_cnt_inc == CW'(TIMEOUT)) begin
          w_state_nxt      = ysyx_24070014_RESP;
          w_resp_valid_nxt = 1'b1;
          w_resp_err_nxt   = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ysyx_24070014_IDLE;
      end
    endcase

    w_req_ready_nxt = (w_state_nxt == ysyx_24070014_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state         <= ysyx_24070014_IDLE;
      r_ctrl          <= '0;
      r_off           <= '0;
      r_cnt           <= '0;
      r_req_ready     <= 1'b1;
      r_resp_valid    <= 1'b0;
      r_resp_err      <= 1'b0;
      r_resp_rdata    <= '0;
      r_mem_req_valid <= 1'b0;
      r_mem_addr      <= '0;
      r_mem_wen       <= 1'b0;
      r_mem_wdata     <= '0;
      r_mem_wstrb     <= '0;
    end else begin
      r_state         <= w_state_nxt;
      r_ctrl          <= w_ctrl_nxt;
      r_off           <= w_off_nxt;
      r_cnt           <= w_cnt_nxt;
      r_req_ready     <= w_req_ready_nxt;
      r_resp_valid    <= w_resp_valid_nxt;
      r_resp_err      <= w_resp_err_nxt;
      r_resp_rdata    <= w_resp_rdata_nxt;
      r_mem_req_valid <= w_mem_req_valid_nxt;
      r_mem_addr      <= w_mem_addr_nxt;
      r_mem_wen       <= w_mem_wen_nxt;
      r_mem_wdata     <= w_mem_wdata_nxt;
      r_mem_wstrb     <= w_mem_wstrb_nxt;
    end
  end

  assign req_ready     = r_req_ready;
  assign resp_valid    = r_resp_valid;
  assign resp_err      = r_resp_err;
  assign resp_rdata    = r_resp_rdata;
  assign mem_req_valid = r_mem_req_valid;
  assign mem_addr      = r_mem_addr;
  assign mem_wen       = r_mem_wen;
  assign mem_wdata     = r_mem_wdata;
  assign mem_wstrb     = r_mem_wstrb;

endmodule

// File: tb/tb_ysyx_24070014_lsu.sv
// Directed bench for the LSU: a 32-bit instance (TIMEOUT=4) driven from a
// vector table plus corner sequences, and a 64-bit instance for dword/reset.
module tb_ysyx_24070014_lsu;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // 32-bit instance signals
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  // 64-bit instance signals
  logic        b_req_valid, b_req_ready, b_req_write, b_req_unsigned;
  logic [1:0]  b_req_size;
  logic [31:0] b_req_addr;
  logic [63:0] b_req_wdata;
  logic        b_resp_valid, b_resp_err;
  logic [63:0] b_resp_rdata;
  logic        b_mem_req_valid, b_mem_req_ready, b_mem_wen, b_mem_resp_valid;
  logic [31:0] b_mem_addr;
  logic [63:0] b_mem_wdata, b_mem_rdata;
  logic [7:0]  b_mem_wstrb;

  int checks   = 0;
  int failures = 0;

  ysyx_24070014_lsu #(.DATA_LEN(32), .ADDR_LEN(32), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
  );

  ysyx_24070014_lsu #(.DATA_LEN(64), .ADDR_LEN(32), .TIMEOUT(4)) dut64 (
    .clk(clk), .reset(reset),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
    .req_size(b_req_size), .req_unsigned(b_req_unsigned), .req_addr(b_req_addr),
    .req_wdata(b_req_wdata), .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata),
    .resp_err(b_resp_err), .mem_req_valid(b_mem_req_valid), .mem_req_ready(b_mem_req_ready),
    .mem_addr(b_mem_addr), .mem_wen(b_mem_wen), .mem_wdata(b_mem_wdata),
    .mem_wstrb(b_mem_wstrb), .mem_resp_valid(b_mem_resp_valid), .mem_rdata(b_mem_rdata)
  );

  typedef struct {
    logic        wr;
    logic [1:0]  sz;
    logic        un;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mrdata;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic [3:0]  wstrb;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Called just after a negedge with all 32-bit inputs idle; returns likewise.
  task automatic run_vec(input vec_t v, input int idx);
    chk($sformatf("v%0d_req_ready", idx), 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_write = v.wr; req_size = v.sz; req_unsigned = v.un;
    req_addr = v.addr; req_wdata = v.wdata;
    @(negedge clk);
    req_valid = 1'b0;
    if (v.err) begin
      chk($sformatf("v%0d_no_mem_req", idx), 64'(mem_req_valid), 64'd0);
      chk($sformatf("v%0d_resp_valid", idx), 64'(resp_valid), 64'd1);
      chk($sformatf("v%0d_resp_err", idx), 64'(resp_err), 64'd1);
      chk($sformatf("v%0d_resp_rdata", idx), 64'(resp_rdata), 64'd0);
      @(negedge clk);
      chk($sformatf("v%0d_no_mem_req2", idx), 64'(mem_req_valid), 64'd0);
      chk($sformatf("v%0d_resp_drop", idx), 64'(resp_valid), 64'd0);
    end else begin
      chk($sformatf("v%0d_mem_req_valid", idx), 64'(mem_req_valid), 64'd1);
      chk($sformatf("v%0d_mem_addr", idx), 64'(mem_addr), 64'(v.maddr));
      chk($sformatf("v%0d_mem_wen", idx), 64'(mem_wen), 64'(v.wr));
      chk($sformatf("v%0d_mem_wdata", idx), 64'(mem_wdata), 64'(v.mwdata));
      chk($sformatf("v%0d_mem_wstrb", idx), 64'(mem_wstrb), 64'(v.wstrb));
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      chk($sformatf("v%0d_req_drop", idx), 64'(mem_req_valid), 64'd0);
      chk($sformatf("v%0d_resp_early", idx), 64'(resp_valid), 64'd0);
      mem_resp_valid = 1'b1; mem_rdata = v.mrdata;
      @(negedge clk);
      mem_resp_valid = 1'b0;
      chk($sformatf("v%0d_resp_valid", idx), 64'(resp_valid), 64'd1);
      chk($sformatf("v%0d_resp_err", idx), 64'(resp_err), 64'd0);
      chk($sformatf("v%0d_resp_rdata", idx), 64'(resp_rdata), 64'(v.rdata));
      @(negedge clk);
      chk($sformatf("v%0d_resp_drop", idx), 64'(resp_valid), 64'd0);
    end
  endtask

  task automatic run64(input string nm, input logic wr, input logic [1:0] sz, input logic un,
                       input logic [31:0] addr, input logic [63:0] wdata,
                       input logic [63:0] mrdata, input logic [31:0] maddr,
                       input logic [63:0] mwdata, input logic [7:0] wstrb,
                       input logic [63:0] rdata);
    chk({nm, "_req_ready"}, 64'(b_req_ready), 64'd1);
    b_req_valid = 1'b1; b_req_write = wr; b_req_size = sz; b_req_unsigned = un;
    b_req_addr = addr; b_req_wdata = wdata;
    @(negedge clk);
    b_req_valid = 1'b0;
    chk({nm, "_mem_req_valid"}, 64'(b_mem_req_valid), 64'd1);
    chk({nm, "_mem_addr"}, 64'(b_mem_addr), 64'(maddr));
    chk({nm, "_mem_wdata"}, b_mem_wdata, mwdata);
    chk({nm, "_mem_wstrb"}, 64'(b_mem_wstrb), 64'(wstrb));
    b_mem_req_ready = 1'b1;
    @(negedge clk);
    b_mem_req_ready = 1'b0;
    b_mem_resp_valid = 1'b1; b_mem_rdata = mrdata;
    @(negedge clk);
    b_mem_resp_valid = 1'b0;
    chk({nm, "_resp_valid"}, 64'(b_resp_valid), 64'd1);
    chk({nm, "_resp_err"}, 64'(b_resp_err), 64'd0);
    chk({nm, "_resp_rdata"}, b_resp_rdata, rdata);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //           wr    sz    un    addr          wdata         mrdata        err   rdata         maddr         mwdata        wstrb
    vecs[0]  = '{1'b0, 2'd0, 1'b0, 32'h80000003, 32'h00000000, 32'h80FF1234, 1'b0, 32'hFFFFFF80, 32'h80000000, 32'h00000000, 4'h0};
    vecs[1]  = '{1'b1, 2'd1, 1'b0, 32'h80000002, 32'h0000ABCD, 32'h00000000, 1'b0, 32'h00000000, 32'h80000000, 32'hABCD0000, 4'hC};
    vecs[2]  = '{1'b0, 2'd0, 1'b1, 32'h80000003, 32'h00000000, 32'h80FF1234, 1'b0, 32'h00000080, 32'h80000000, 32'h00000000, 4'h0};
    vecs[3]  = '{1'b0, 2'd1, 1'b0, 32'h80000002, 32'h00000000, 32'h80FF1234, 1'b0, 32'hFFFF80FF, 32'h80000000, 32'h00000000, 4'h0};
    vecs[4]  = '{1'b0, 2'd1, 1'b1, 32'h80000000, 32'h00000000, 32'h80FF8234, 1'b0, 32'h00008234, 32'h80000000, 32'h00000000, 4'h0};
    vecs[5]  = '{1'b0, 2'd2, 1'b0, 32'h80000004, 32'h00000000, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 32'h80000004, 32'h00000000, 4'h0};
    vecs[6]  = '{1'b1, 2'd0, 1'b0, 32'h10000001, 32'h123456A5, 32'hFFFFFFFF, 1'b0, 32'h00000000, 32'h10000000, 32'h3456A500, 4'h2};
    vecs[7]  = '{1'b1, 2'd2, 1'b0, 32'h00000020, 32'hCAFEF00D, 32'h00000000, 1'b0, 32'h00000000, 32'h00000020, 32'hCAFEF00D, 4'hF};
    vecs[8]  = '{1'b0, 2'd2, 1'b0, 32'h80000001, 32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 32'h00000000, 32'h00000000, 4'h0};
    vecs[9]  = '{1'b0, 2'd1, 1'b0, 32'h00000003, 32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 32'h00000000, 32'h00000000, 4'h0};
    vecs[10] = '{1'b0, 2'd3, 1'b0, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 32'h00000000, 32'h00000000, 4'h0};
    vecs[11] = '{1'b1, 2'd2, 1'b0, 32'h00000002, 32'h11111111, 32'h00000000, 1'b1, 32'h00000000, 32'h00000000, 32'h00000000, 4'h0};
    vecs[12] = '{1'b0, 2'd0, 1'b0, 32'h80000004, 32'h00000000, 32'h0000007F, 1'b0, 32'h0000007F, 32'h80000004, 32'h00000000, 4'h0};
    vecs[13] = '{1'b0, 2'd0, 1'b0, 32'h80000002, 32'h00000000, 32'h00FE0000, 1'b0, 32'hFFFFFFFE, 32'h80000000, 32'h00000000, 4'h0};

    reset = 1'b0;
    req_valid = 0; req_write = 0; req_size = 0; req_unsigned = 0; req_addr = 0; req_wdata = 0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = 0;
    b_req_valid = 0; b_req_write = 0; b_req_size = 0; b_req_unsigned = 0; b_req_addr = 0;
    b_req_wdata = 0; b_mem_req_ready = 0; b_mem_resp_valid = 0; b_mem_rdata = 0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_err", 64'(resp_err), 64'd0);
    chk("rst_resp_rdata", 64'(resp_rdata), 64'd0);
    chk("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
    chk("rst_mem_wen", 64'(mem_wen), 64'd0);
    chk("rst_mem_wstrb", 64'(mem_wstrb), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd1);

    for (int i = 0; i < 14; i++) run_vec(vecs[i], i);

    // Stray memory response while idle is ignored
    mem_resp_valid = 1'b1; mem_rdata = 32'hA5A5A5A5;
    @(negedge clk);
    @(negedge clk);
    mem_resp_valid = 1'b0;
    chk("stray_idle_resp", 64'(resp_valid), 64'd0);
    chk("stray_idle_ready", 64'(req_ready), 64'd1);

    // Timeout after 4 WAIT cycles
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h40;
    @(negedge clk);
    req_valid = 1'b0;
    chk("to_mem_req_valid", 64'(mem_req_valid), 64'd1);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("to_wait%0d_resp", k), 64'(resp_valid), 64'd0);
      chk($sformatf("to_wait%0d_ready", k), 64'(req_ready), 64'd0);
      @(negedge clk);
    end
    chk("to_resp_valid", 64'(resp_valid), 64'd1);
    chk("to_resp_err", 64'(resp_err), 64'd1);
    chk("to_resp_rdata", 64'(resp_rdata), 64'd0);
    @(negedge clk);
    chk("to_after_ready", 64'(req_ready), 64'd1);
    chk("to_after_resp", 64'(resp_valid), 64'd0);

    // Response on the timeout cycle wins
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h44;
    @(negedge clk);
    req_valid = 1'b0;
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("race_w4_resp", 64'(resp_valid), 64'd0);
    mem_resp_valid = 1'b1; mem_rdata = 32'h11223344;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    chk("race_resp_valid", 64'(resp_valid), 64'd1);
    chk("race_resp_err", 64'(resp_err), 64'd0);
    chk("race_resp_rdata", 64'(resp_rdata), 64'h11223344);
    @(negedge clk);

    // Memory handshake delayed 5 cycles: request fields must hold
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd1; req_addr = 32'h80000002; req_wdata = 32'h0000ABCD;
    @(negedge clk);
    req_valid = 1'b0; req_wdata = 32'hFFFFFFFF; req_addr = 32'h0;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("dly%0d_mem_req_valid", k), 64'(mem_req_valid), 64'd1);
      chk($sformatf("dly%0d_mem_addr", k), 64'(mem_addr), 64'h80000000);
      chk($sformatf("dly%0d_mem_wdata", k), 64'(mem_wdata), 64'hABCD0000);
      chk($sformatf("dly%0d_mem_wstrb", k), 64'(mem_wstrb), 64'hC);
      chk($sformatf("dly%0d_resp", k), 64'(resp_valid), 64'd0);
      mem_resp_valid = 1'b1;
      @(negedge clk);
    end
    mem_resp_valid = 1'b0;
    chk("dly_hs_mem_addr", 64'(mem_addr), 64'h80000000);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    chk("dly_resp_valid", 64'(resp_valid), 64'd1);
    chk("dly_resp_err", 64'(resp_err), 64'd0);
    chk("dly_resp_rdata", 64'(resp_rdata), 64'd0);
    @(negedge clk);
    chk("dly_single_pulse", 64'(resp_valid), 64'd0);
    @(negedge clk);
    chk("dly_single_pulse2", 64'(resp_valid), 64'd0);

    // 64-bit instance
    run64("d_dword", 1'b0, 2'd3, 1'b1, 32'h8, 64'h0, 64'h8877665544332211,
          32'h8, 64'h0, 8'h00, 64'h8877665544332211);
    run64("d_byte5", 1'b0, 2'd0, 1'b0, 32'h5, 64'h0, 64'h000080FF00000000,
          32'h0, 64'h0, 8'h00, 64'hFFFFFFFFFFFFFF80);
    run64("d_sw4", 1'b1, 2'd2, 1'b0, 32'h4, 64'h00000000CAFEF00D, 64'h0,
          32'h0, 64'hCAFEF00D00000000, 8'hF0, 64'h0);
    run64("d_lw12", 1'b0, 2'd2, 1'b0, 32'hC, 64'h0, 64'h8000000100000000,
          32'h8, 64'h0, 8'h00, 64'hFFFFFFFF80000001);

    // Reset during WAIT abandons the transaction
    b_req_valid = 1'b1; b_req_write = 1'b0; b_req_size = 2'd3; b_req_unsigned = 1'b1; b_req_addr = 32'h8;
    @(negedge clk);
    b_req_valid = 1'b0;
    chk("rw_mem_req_valid", 64'(b_mem_req_valid), 64'd1);
    b_mem_req_ready = 1'b1;
    @(negedge clk);
    b_mem_req_ready = 1'b0;
    chk("rw_in_wait_ready", 64'(b_req_ready), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rw_rst_resp", 64'(b_resp_valid), 64'd0);
    chk("rw_rst_mem_req", 64'(b_mem_req_valid), 64'd0);
    chk("rw_rst_wstrb", 64'(b_mem_wstrb), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rw_ready_after", 64'(b_req_ready), 64'd1);
    chk("rw_resp_after", 64'(b_resp_valid), 64'd0);
    b_mem_resp_valid = 1'b1; b_mem_rdata = 64'h1234;
    @(negedge clk);
    b_mem_resp_valid = 1'b0;
    chk("rw_stray_resp", 64'(b_resp_valid), 64'd0);
    @(negedge clk);
    chk("rw_stray_resp2", 64'(b_resp_valid), 64'd0);
    chk("rw_idle_ready", 64'(b_req_ready), 64'd1);
    chk("rw_dut32_ready", 64'(req_ready), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
